// File: rtl/pipe_stage_chain_pkg.sv
// Shared constants for the pipeline register chain: depth limit, default widths,
// and bit positions of the control bundle and payload fields.
package pipe_pkg;

    localparam int unsigned DEPTH_MAX       = 4;
    localparam int unsigned CTRL_W_DEF      = 12;
    localparam int unsigned DATA_W_DEF      = 133;
    localparam int unsigned STALL_CNT_W_DEF = 16;

    // Control bundle field offsets (LSB first); bits 11:10 are spare.
    localparam int unsigned CTRL_WREG_OFS   = 0;
    localparam int unsigned CTRL_M2REG_OFS  = 1;
    localparam int unsigned CTRL_WMEM_OFS   = 2;
    localparam int unsigned CTRL_ALUIMM_OFS = 3;
    localparam int unsigned CTRL_SHIFT_OFS  = 4;
    localparam int unsigned CTRL_JAL_OFS    = 5;
    localparam int unsigned CTRL_ALUC_OFS   = 6;
    localparam int unsigned CTRL_ALUC_W     = 4;

    // Payload field offsets: a, b, imm, pc4 are 32 bits, rn is 5 bits.
    localparam int unsigned DATA_A_OFS   = 0;
    localparam int unsigned DATA_B_OFS   = 32;
    localparam int unsigned DATA_IMM_OFS = 64;
    localparam int unsigned DATA_PC4_OFS = 96;
    localparam int unsigned DATA_RN_OFS  = 128;
    localparam int unsigned DATA_RN_W    = 5;

    typedef struct packed {
        logic [1:0]             spare;
        logic [CTRL_ALUC_W-1:0] aluc;
        logic                   jal;
        logic                   shift;
        logic                   aluimm;
        logic                   wmem;
        logic                   m2reg;
        logic                   wreg;
    } ctrl_bundle_t;

endpackage

// File: rtl/pipe_stage_chain_if.sv
// Instruction slot entering and leaving the register chain.
interface pipe_stage_chain_if #(
    parameter int unsigned CTRL_W = 12,
    parameter int unsigned DATA_W = 133
);

    logic              in_valid;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_ctrl, in_data,
        input  out_valid, out_ctrl, out_data
    );

    modport slave (
        input  in_valid, in_ctrl, in_data,
        output out_valid, out_ctrl, out_data
    );

endinterface

// File: rtl/pipe_stage_chain_slice.sv
// One pipeline register stage: priority reset > flush > stall > advance.
module pipe_stage_slice #(
    parameter int unsigned CTRL_W = 12,
    parameter int unsigned DATA_W = 133
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              prev_valid_i,
    input  logic [CTRL_W-1:0] prev_ctrl_i,
    input  logic [DATA_W-1:0] prev_data_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
    logic [DATA_W-1:0] data_q,  data_d;

    // A bubble clears valid and ctrl but keeps the payload so it does not toggle.
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else if (!stall_i) begin
            valid_d = prev_valid_i;
            ctrl_d  = prev_ctrl_i;
            data_d  = prev_data_i;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_chain.sv
// Parametrised DEPTH-stage pipeline register chain with global stall and per-stage flush.
// Define PIPE_STALL_CNT_EN to add the saturating stall_cnt output.
module pipe_stage_chain
    import pipe_pkg::*;
#(
    parameter int unsigned DEPTH       = 1,
    parameter int unsigned CTRL_W      = CTRL_W_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned STALL_CNT_W = STALL_CNT_W_DEF
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   stall,
    input  logic [DEPTH-1:0]       flush,
    pipe_stage_chain_if.slave      bus
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

    if (DEPTH < 1 || DEPTH > DEPTH_MAX || STALL_CNT_W < 1) begin : g_bad_cfg
        $error("pipe_stage_chain: DEPTH must be 1..%0d and STALL_CNT_W >= 1", DEPTH_MAX);
    end

    logic              stage_valid [DEPTH];
    logic [CTRL_W-1:0] stage_ctrl  [DEPTH];
    logic [DATA_W-1:0] stage_data  [DEPTH];

    // Invalid input slots never carry write enables into the chain.
    logic [CTRL_W-1:0] in_ctrl_masked;
    assign in_ctrl_masked = bus.in_ctrl & {CTRL_W{bus.in_valid}};

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic              prev_valid;
        logic [CTRL_W-1:0] prev_ctrl;
        logic [DATA_W-1:0] prev_data;

        if (i == 0) begin : g_head
            assign prev_valid = bus.in_valid;
            assign prev_ctrl  = in_ctrl_masked;
            assign prev_data  = bus.in_data;
        end else begin : g_body
            assign prev_valid = stage_valid[i-1];
            assign prev_ctrl  = stage_ctrl[i-1];
            assign prev_data  = stage_data[i-1];
        end

        pipe_stage_slice #(
            .CTRL_W (CTRL_W),
            .DATA_W (DATA_W)
        ) u_slice (
            .clock        (clock),
            .reset        (reset),
            .stall_i      (stall),
            .flush_i      (flush[i]),
            .prev_valid_i (prev_valid),
            .prev_ctrl_i  (prev_ctrl),
            .prev_data_i  (prev_data),
            .valid_o      (stage_valid[i]),
            .ctrl_o       (stage_ctrl[i]),
            .data_o       (stage_data[i])
        );
    end

    assign bus.out_valid = stage_valid[DEPTH-1];
    assign bus.out_ctrl  = stage_ctrl[DEPTH-1];
    assign bus.out_data  = stage_data[DEPTH-1];

`ifdef PIPE_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Self-checking bench: three chains (DEPTH 1, 2, 3) driven in lockstep against a reference model.
module tb_pipe_stage_chain;

    localparam int unsigned CW = 12;
    localparam int unsigned DW = 133;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic [2:0]  fl3   = '0;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned cyc   = 0;

    pipe_stage_chain_if #(.CTRL_W(CW), .DATA_W(DW)) if1 ();
    pipe_stage_chain_if #(.CTRL_W(CW), .DATA_W(DW)) if2 ();
    pipe_stage_chain_if #(.CTRL_W(CW), .DATA_W(DW)) if3 ();

`ifdef PIPE_STALL_CNT_EN
    logic [3:0]  cnt1;
    logic [15:0] cnt2;
    logic [15:0] cnt3;
`endif

    pipe_stage_chain #(.DEPTH(1), .CTRL_W(CW), .DATA_W(DW), .STALL_CNT_W(4)) dut1 (
        .clock (clock), .reset (reset), .stall (stall), .flush (fl3[0:0]), .bus (if1)
`ifdef PIPE_STALL_CNT_EN
        , .stall_cnt (cnt1)
`endif
    );

    pipe_stage_chain #(.DEPTH(2), .CTRL_W(CW), .DATA_W(DW), .STALL_CNT_W(16)) dut2 (
        .clock (clock), .reset (reset), .stall (stall), .flush (fl3[1:0]), .bus (if2)
`ifdef PIPE_STALL_CNT_EN
        , .stall_cnt (cnt2)
`endif
    );

    pipe_stage_chain #(.DEPTH(3), .CTRL_W(CW), .DATA_W(DW), .STALL_CNT_W(16)) dut3 (
        .clock (clock), .reset (reset), .stall (stall), .flush (fl3), .bus (if3)
`ifdef PIPE_STALL_CNT_EN
        , .stall_cnt (cnt3)
`endif
    );

    always #5 clock = ~clock;

    // Reference model: slot contents per stage, per chain (chain k has depth k+1).
    logic          mv [3][4];
    logic [CW-1:0] mc [3][4];
    logic [DW-1:0] md [3][4];
    int unsigned   mcnt [3];
    int unsigned   cmax [3] = '{15, 65535, 65535};

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s (cycle %0d): got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_step(input logic rst, input logic stl, input logic [2:0] fl,
                              input logic iv, input logic [CW-1:0] ic, input logic [DW-1:0] id);
        for (int k = 0; k < 3; k++) begin
            // Walk from the output end so each stage sees its predecessor's old contents.
            for (int i = k; i >= 0; i--) begin
                if (rst) begin
                    mv[k][i] = 1'b0; mc[k][i] = '0; md[k][i] = '0;
                end else if (fl[i]) begin
                    mv[k][i] = 1'b0; mc[k][i] = '0;
                end else if (!stl) begin
                    if (i == 0) begin
                        mv[k][0] = iv; mc[k][0] = iv ? ic : '0; md[k][0] = id;
                    end else begin
                        mv[k][i] = mv[k][i-1]; mc[k][i] = mc[k][i-1]; md[k][i] = md[k][i-1];
                    end
                end
            end
            if (rst) mcnt[k] = 0;
            else if (stl && mcnt[k] < cmax[k]) mcnt[k]++;
        end
    endtask

    task automatic compare_all();
        check("d1_valid", if1.out_valid, mv[0][0]);
        check("d1_ctrl",  if1.out_ctrl,  mc[0][0]);
        check("d1_data",  if1.out_data,  md[0][0]);
        check("d2_valid", if2.out_valid, mv[1][1]);
        check("d2_ctrl",  if2.out_ctrl,  mc[1][1]);
        check("d2_data",  if2.out_data,  md[1][1]);
        check("d3_valid", if3.out_valid, mv[2][2]);
        check("d3_ctrl",  if3.out_ctrl,  mc[2][2]);
        check("d3_data",  if3.out_data,  md[2][2]);
`ifdef PIPE_STALL_CNT_EN
        check("d1_cnt", cnt1, DW'(mcnt[0]));
        check("d2_cnt", cnt2, DW'(mcnt[1]));
        check("d3_cnt", cnt3, DW'(mcnt[2]));
`endif
    endtask

    task automatic drive(input logic rst, input logic stl, input logic [2:0] fl,
                         input logic iv, input logic [CW-1:0] ic, input logic [DW-1:0] id);
        reset = rst; stall = stl; fl3 = fl;
        if1.in_valid = iv; if1.in_ctrl = ic; if1.in_data = id;
        if2.in_valid = iv; if2.in_ctrl = ic; if2.in_data = id;
        if3.in_valid = iv; if3.in_ctrl = ic; if3.in_data = id;
        @(posedge clock);
        model_step(rst, stl, fl, iv, ic, id);
        #1;
        cyc++;
        compare_all();
    endtask

    function automatic logic [DW-1:0] rand_data();
        return DW'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
    endfunction

    initial begin
        logic [DW-1:0] ones;
        ones = '1;

        // Reset dominates a valid input
        drive(1, 0, 3'b000, 1, 12'hABC, ones);
        drive(1, 0, 3'b000, 1, 12'hABC, ones);
        check("rst_valid", if3.out_valid, 0);
        check("rst_ctrl",  if3.out_ctrl,  0);
        check("rst_data",  if1.out_data,  0);
`ifdef PIPE_STALL_CNT_EN
        check("rst_cnt", cnt1, 0);
`endif

        // Streaming through three stages
        drive(0, 0, 3'b000, 1, 12'h001, rand_data());
        drive(0, 0, 3'b000, 1, 12'h002, rand_data());
        drive(0, 0, 3'b000, 1, 12'h003, rand_data());
        check("stream_c1", if3.out_ctrl, 12'h001);
        drive(0, 0, 3'b000, 1, 12'h004, rand_data());
        check("stream_c2", if3.out_ctrl, 12'h002);
        drive(0, 0, 3'b000, 1, 12'h005, rand_data());
        check("stream_c3", if3.out_ctrl, 12'h003);
        check("stream_v",  if3.out_valid, 1);

        // Stall holds a single-stage chain
        drive(1, 0, 3'b000, 0, 12'h000, '0);
        drive(0, 0, 3'b000, 1, 12'h005, DW'(16'h1234));
        for (int n = 0; n < 4; n++) begin
            drive(0, 1, 3'b000, 1, 12'h007, DW'(16'h5678));
            check("stall_ctrl", if1.out_ctrl, 12'h005);
            check("stall_data", if1.out_data, DW'(16'h1234));
        end
`ifdef PIPE_STALL_CNT_EN
        check("stall_cnt4", cnt1, 4);
`endif
        drive(0, 0, 3'b000, 1, 12'h007, DW'(16'h5678));
        check("stall_release", if1.out_ctrl, 12'h007);

        // Flush on the last stage while stalled
        drive(0, 0, 3'b000, 1, 12'h011, DW'(8'hA1));
        drive(0, 0, 3'b000, 1, 12'h022, DW'(8'hA2));
        drive(0, 1, 3'b010, 1, 12'h033, DW'(8'hA3));
        check("flush_valid", if2.out_valid, 0);
        check("flush_ctrl",  if2.out_ctrl,  0);
        check("flush_data",  if2.out_data,  DW'(8'hA1));
        drive(0, 0, 3'b000, 0, 12'h000, '0);
        check("flush_s0_valid", if2.out_valid, 1);
        check("flush_s0_ctrl",  if2.out_ctrl,  12'h022);

        // Invalid input is masked but payload passes
        for (int n = 0; n < 3; n++) drive(0, 0, 3'b000, 0, 12'hFFF, DW'(16'hDEAD));
        check("mask_valid", if3.out_valid, 0);
        check("mask_ctrl",  if3.out_ctrl,  0);
        check("mask_data",  if3.out_data,  DW'(16'hDEAD));

        // Saturation, then reset while stalled
        drive(1, 0, 3'b000, 0, 12'h000, '0);
        for (int n = 0; n < 20; n++) drive(0, 1, 3'b000, 1, 12'h0F0, rand_data());
`ifdef PIPE_STALL_CNT_EN
        check("sat_cnt1", cnt1, 15);
        check("sat_cnt2", cnt2, 20);
`endif
        drive(1, 1, 3'b000, 1, 12'h0F0, rand_data());
`ifdef PIPE_STALL_CNT_EN
        check("sat_rst", cnt1, 0);
`endif

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            logic [2:0] fl;
            for (int b = 0; b < 3; b++) fl[b] = ($urandom_range(0, 9) == 0);
            drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0), fl,
                  1'($urandom()), CW'($urandom()), rand_data());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
